run_ctl: RTL and testbench
==========================

# run_ctl

Run-control state machine for the control board. It owns the three signals that gate the microcode sequencer: reset hold (`nrsthold`), halt (`nhalt`) and wait state (`nws`). It turns front-panel/DFP requests (run, stop, micro-step, instruction-step) and device wait requests into cycle-exact gating. Stops and instruction steps always land on an instruction boundary, detected from the sequencer's `nend`.

## Interface

Clocking: one clock, `clk4`; reset is synchronous and active-high (`reset`).

Parameters:
- `RSTHOLD_CYCLES`, default 16: cycles `nrsthold` stays low after `reset` deasserts.
- `WS_MAX`, default 15: maximum consecutive wait-state cycles before forced release.
- `START_RUNNING`, default 1: 1 means enter RUN after reset hold; 0 means enter HALT.

Ports:
- `clk4` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `fp_run` in 1: single-cycle pulse, request free run.
- `fp_stop` in 1: single-cycle pulse, request halt at the next instruction boundary.
- `fp_ustep` in 1: single-cycle pulse, execute exactly one microstep.
- `fp_istep` in 1: single-cycle pulse, execute up to the next instruction boundary.
- `nend` in 1: sequencer end-of-microprogram, active low.
- `wait_req` in 1: device wait request, active high.
- `nrsthold` out 1: sequencer reset hold, active low.
- `nhalt` out 1: sequencer count enable, low while halted.
- `nws` out 1: wait state, active low.
- `state` out 3: current state code, for the front panel.
- `ws_timeout` out 1: one-cycle pulse when a wait is force-released.

## Operation

State codes:
- RSTHOLD=0, RUN=1, STOPPING=2, HALT=3, USTEP=4, ISTEP=5.

Outputs by state:
- `nrsthold` is 0 only in RSTHOLD.
- `nhalt` is 1 in RUN, STOPPING, USTEP and ISTEP; 0 in RSTHOLD and HALT.
- All outputs are registered.

Definitions:
- An "active cycle" is a cycle with `nhalt`=1 and `nws`=1.
- A "boundary" is an active cycle with `nend`=0.

Transitions:
- **RSTHOLD:** a hold counter counts `RSTHOLD_CYCLES`. When it expires, go to RUN if `START_RUNNING`=1, else HALT. All `fp_*` inputs are ignored.
- **HALT:**
  - `fp_run` → RUN.
  - `fp_ustep` → USTEP.
  - `fp_istep` → ISTEP.
  - Priority when several are asserted together: run > istep > ustep.
- **RUN:**
  - `fp_stop` → STOPPING.
  - A boundary in the same cycle as `fp_stop` → HALT directly.
  - `fp_ustep` and `fp_istep` are ignored.
- **STOPPING:** a boundary → HALT. `fp_run` cancels the stop and returns to RUN.
- **USTEP:** the first active cycle → HALT.
- **ISTEP:** a boundary → HALT. `fp_stop` → HALT immediately, without waiting for a boundary.
- **reset:** `reset`=1 in any state, including mid-wait or mid-step, → RSTHOLD on the next edge. The hold counter reloads.

Wait states:
- When `wait_req`=1 in RUN, STOPPING, USTEP or ISTEP, `nws` goes 0 on the next edge and stays 0 while `wait_req` stays high.
- `nws` is forced 1 in RSTHOLD and HALT.
- The wait counter counts consecutive `nws`=0 cycles. After `WS_MAX` such cycles, `nws` is forced to 1 for at least one cycle and `ws_timeout` pulses for one cycle. The counter clears whenever `nws`=1.
- A wait in progress does not block the transition to HALT caused by `fp_stop` in ISTEP; `nws` is released on that same edge.

## Timing

Reset values (cycle after `reset` is sampled high):
- `nrsthold`=0, `nhalt`=0, `nws`=1, `state`=0, `ws_timeout`=0.

Latencies:
- `fp_*` pulse → `state`/`nhalt` change: 1 cycle.
- `wait_req` → `nws`: 1 cycle.
- `nend`=0 boundary sampled at edge N → `nhalt`=0 from edge N+1. The sequencer's µPC reload to 0 happens at edge N, so it is not blocked.

Exact durations:
- USTEP holds `nhalt`=1 for exactly 1 active cycle plus any wait cycles.
- After reset deassertion, RSTHOLD lasts exactly `RSTHOLD_CYCLES` cycles.

## Structure

- `run_ctl_defs.v` holds the state-code `define`s. The front-panel decode shares this file.
- Sub-module `ws_timer`: wait-state counter plus timeout pulse, parameterised by `WS_MAX`. Everything else is flat in `run_ctl`.

## Test plan

- **Reset and hold:** `reset` high for 3 cycles, then low, `START_RUNNING`=1 → `nrsthold`=0 for exactly 16 cycles, then `nrsthold`=1, `nhalt`=1, `state`=1.
- **Stop at boundary:** in RUN, pulse `fp_stop`; drive `nend`=0 4 cycles later → `state`=2 for 4 cycles, then `state`=3 and `nhalt`=0 on the edge after the `nend` sample.
- **Micro-step:** in HALT, pulse `fp_ustep` with `wait_req` held high for 2 cycles → `nhalt`=1 for 1 active cycle plus the 2 wait cycles, then HALT.
- **Wait timeout:** in RUN, hold `wait_req`=1 for 30 cycles with `WS_MAX`=15 → `nws`=0 for 15 cycles, then `nws`=1 for one cycle with a `ws_timeout` pulse, then `nws`=0 again.
- **Instruction step:** in HALT, pulse `fp_istep`; drive `nend`=0 on the 6th active cycle → HALT on the following edge.
- **Reset mid-operation:** assert `reset` during an ISTEP wait → next cycle `state`=0, `nws`=1, `nhalt`=0.
- **Simultaneous requests:** in HALT, pulse `fp_run` and `fp_istep` in the same cycle → `state`=1 (RUN wins).

Source files
------------

// File: rtl/run_ctl_pkg.sv
// Shared definitions for the run-control block: state codes as seen on the
// front panel, plus a decode helper for the "sequencer is clocking" states.
package run_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RSTHOLD  = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOPPING = 3'd2,
        ST_HALT     = 3'd3,
        ST_USTEP    = 3'd4,
        ST_ISTEP    = 3'd5
    } rc_state_e;

    // States in which the sequencer counts (nhalt high) and waits may be inserted.
    function automatic logic is_running(rc_state_e s);
        return (s == ST_RUN) || (s == ST_STOPPING) || (s == ST_USTEP) || (s == ST_ISTEP);
    endfunction

endpackage

// File: rtl/run_ctl_ws_timer.sv
// Wait-state watchdog: counts consecutive cycles with nws low and flags the
// cycle on which the wait must be force-released, plus a one-cycle pulse.
module ws_timer
    import run_ctl_pkg::*;
#(
    parameter int WS_MAX = 15
) (
    input  logic clk4_i,
    input  logic reset_i,
    input  logic nws_i,        // current registered nws
    input  logic want_wait_i,  // a wait would otherwise be held next cycle
    output logic expire_o,     // this is the last allowed wait cycle
    output logic ws_timeout_o
);

    localparam int CW = (WS_MAX > 1) ? $clog2(WS_MAX + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WS_MAX - 1);

    logic [CW-1:0] cnt_q;
    logic          ws_timeout_q;

    // cnt_q holds the number of low cycles already completed before this one
    assign expire_o     = ~nws_i && (cnt_q == LAST);
    assign ws_timeout_o = ws_timeout_q;

    // Count wait cycles; clear whenever nws is high or the wait is being cut
    always_ff @(posedge clk4_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            ws_timeout_q <= 1'b0;
        end else begin
            if (nws_i || expire_o) cnt_q <= '0;
            else                   cnt_q <= cnt_q + CW'(1);
            // pulse only when the release is actually forced, not when the
            // request drops or a halt releases nws on the same edge
            ws_timeout_q <= expire_o & want_wait_i;
        end
    end

endmodule

// File: rtl/run_ctl.sv
// Run-control FSM: gates the microcode sequencer via nrsthold/nhalt/nws.
// Stops and instruction steps complete on an instruction boundary, i.e. an
// active cycle (nhalt=1, nws=1) in which the sequencer reports nend low.
module run_ctl
    import run_ctl_pkg::*;
#(
    parameter int RSTHOLD_CYCLES = 16,
    parameter int WS_MAX         = 15,
    parameter bit START_RUNNING  = 1'b1
) (
    input  logic       clk4,
    input  logic       reset,
    input  logic       fp_run,
    input  logic       fp_stop,
    input  logic       fp_ustep,
    input  logic       fp_istep,
    input  logic       nend,
    input  logic       wait_req,
    output logic       nrsthold,
    output logic       nhalt,
    output logic       nws,
    output logic [2:0] state,
    output logic       ws_timeout
);

    localparam int HW = (RSTHOLD_CYCLES > 1) ? $clog2(RSTHOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RSTHOLD_CYCLES - 1);

    rc_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          nrsthold_q, nhalt_q, nws_q, nws_d;
    logic          active, boundary, want_wait, ws_expire;

    assign active   = nhalt_q & nws_q;
    assign boundary = active & ~nend;

    // Next-state decode; front-panel requests are single-cycle pulses
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_RSTHOLD: begin
                if (hold_q == '0) state_d = START_RUNNING ? ST_RUN : ST_HALT;
                else              hold_d  = hold_q - HW'(1);
            end
            ST_HALT: begin
                if (fp_run)        state_d = ST_RUN;
                else if (fp_istep) state_d = ST_ISTEP;
                else if (fp_ustep) state_d = ST_USTEP;
            end
            ST_RUN: begin
                if (fp_stop) state_d = boundary ? ST_HALT : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (fp_run)        state_d = ST_RUN;
                else if (boundary) state_d = ST_HALT;
            end
            ST_USTEP: begin
                if (active) state_d = ST_HALT;
            end
            ST_ISTEP: begin
                if (fp_stop || boundary) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // A wait is only held while the sequencer will still be running next cycle
    assign want_wait = wait_req & is_running(state_d);
    assign nws_d     = ~(want_wait & ~ws_expire);

    ws_timer #(.WS_MAX(WS_MAX)) u_ws_timer (
        .clk4_i       (clk4),
        .reset_i      (reset),
        .nws_i        (nws_q),
        .want_wait_i  (want_wait),
        .expire_o     (ws_expire),
        .ws_timeout_o (ws_timeout)
    );

    // State, hold counter and registered gating outputs decoded from next state
    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q    <= ST_RSTHOLD;
            hold_q     <= HOLD_INIT;
            nrsthold_q <= 1'b0;
            nhalt_q    <= 1'b0;
            nws_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            nrsthold_q <= (state_d != ST_RSTHOLD);
            nhalt_q    <= is_running(state_d);
            nws_q      <= nws_d;
        end
    end

    assign nrsthold = nrsthold_q;
    assign nhalt    = nhalt_q;
    assign nws      = nws_q;
    assign state    = state_q;

endmodule

// File: tb/tb_run_ctl.sv
// Directed bench for run_ctl. The driver pushes the hand-computed expected
// outputs for the cycle following each edge; a monitor pops and compares.
module tb_run_ctl;

    logic       clk4 = 1'b0;
    logic       reset = 1'b1;
    logic       fp_run = 1'b0, fp_stop = 1'b0, fp_ustep = 1'b0, fp_istep = 1'b0;
    logic       nend = 1'b1, wait_req = 1'b0;
    logic       nrsthold, nhalt, nws, ws_timeout;
    logic [2:0] state;

    run_ctl #(.RSTHOLD_CYCLES(16), .WS_MAX(15), .START_RUNNING(1'b1)) dut (
        .clk4(clk4), .reset(reset), .fp_run(fp_run), .fp_stop(fp_stop),
        .fp_ustep(fp_ustep), .fp_istep(fp_istep), .nend(nend), .wait_req(wait_req),
        .nrsthold(nrsthold), .nhalt(nhalt), .nws(nws), .state(state),
        .ws_timeout(ws_timeout)
    );

    always #5 clk4 = ~clk4;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       nr, nh, nw, to;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk4) cyc <= cyc + 1;

    task automatic chk(input string nm, input int c, input logic [2:0] got, input logic [2:0] want);
        if ($isunknown(want)) return;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, got, want);
        end
    endtask

    // Monitor: compare outputs mid-cycle against the entry for this cycle
    exp_t e;
    always @(negedge clk4) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("state",      e.cyc, state,      e.st);
            chk("nrsthold",   e.cyc, nrsthold,   e.nr);
            chk("nhalt",      e.cyc, nhalt,      e.nh);
            chk("nws",        e.cyc, nws,        e.nw);
            chk("ws_timeout", e.cyc, ws_timeout, e.to);
        end
    end

    // Expect state st (nrsthold/nhalt follow the output table) after next edge
    task automatic tk(input logic [2:0] st, input logic nw, input logic to);
        exp_t x;
        x.cyc = cyc + 1;
        x.st  = st;
        x.nr  = (st != 3'd0);
        x.nh  = (st == 3'd1) || (st == 3'd2) || (st == 3'd4) || (st == 3'd5);
        x.nw  = nw;
        x.to  = to;
        q.push_back(x);
        @(posedge clk4);
        #1;
        fp_run = 1'b0; fp_stop = 1'b0; fp_ustep = 1'b0; fp_istep = 1'b0;
    endtask

    initial begin
        // Reset 3 cycles, then exactly 16 cycles of hold, then RUN
        repeat (3) tk(3'd0, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (15) tk(3'd0, 1'b1, 1'b0);
        tk(3'd1, 1'b1, 1'b0);

        // RUN ignores a bare boundary and a micro-step request
        nend = 1'b0; tk(3'd1, 1'b1, 1'b0);
        nend = 1'b1; fp_ustep = 1'b1; tk(3'd1, 1'b1, 1'b0);

        // Stop: STOPPING for 4 cycles, HALT after the boundary sample
        fp_stop = 1'b1; tk(3'd2, 1'b1, 1'b0);
        repeat (3) tk(3'd2, 1'b1, 1'b0);
        nend = 1'b0; tk(3'd3, 1'b1, 1'b0);
        nend = 1'b1; tk(3'd3, 1'b1, 1'b0);

        // Micro-step with 2 wait cycles, then one active cycle
        fp_ustep = 1'b1; wait_req = 1'b1; tk(3'd4, 1'b0, 1'b0);
        tk(3'd4, 1'b0, 1'b0);
        wait_req = 1'b0; tk(3'd4, 1'b1, 1'b0);
        tk(3'd3, 1'b1, 1'b0);
        tk(3'd3, 1'b1, 1'b0);

        // Instruction step: boundary on the 6th active cycle
        fp_istep = 1'b1; tk(3'd5, 1'b1, 1'b0);
        repeat (5) tk(3'd5, 1'b1, 1'b0);
        nend = 1'b0; tk(3'd3, 1'b1, 1'b0);
        nend = 1'b1; tk(3'd3, 1'b1, 1'b0);

        // Run beats istep
        fp_run = 1'b1; fp_istep = 1'b1; tk(3'd1, 1'b1, 1'b0);

        // Stop cancelled by run
        fp_stop = 1'b1; tk(3'd2, 1'b1, 1'b0);
        fp_run  = 1'b1; tk(3'd1, 1'b1, 1'b0);

        // Wait timeout: 15 low, forced high with pulse, low again
        wait_req = 1'b1;
        repeat (15) tk(3'd1, 1'b0, 1'b0);
        tk(3'd1, 1'b1, 1'b1);
        repeat (14) tk(3'd1, 1'b0, 1'b0);
        wait_req = 1'b0; tk(3'd1, 1'b1, 1'bx);

        // Stop coinciding with a boundary halts directly
        fp_stop = 1'b1; nend = 1'b0; tk(3'd3, 1'b1, 1'b0);
        nend = 1'b1;

        // istep beats ustep; stop in ISTEP halts without a boundary
        fp_istep = 1'b1; fp_ustep = 1'b1; tk(3'd5, 1'b1, 1'b0);
        fp_stop = 1'b1; tk(3'd3, 1'b1, 1'b0);

        // Plain micro-step: one active cycle
        fp_ustep = 1'b1; tk(3'd4, 1'b1, 1'b0);
        tk(3'd3, 1'b1, 1'b0);

        // Stop during an ISTEP wait releases nws on the same edge; HALT forces nws high
        fp_istep = 1'b1; wait_req = 1'b1; tk(3'd5, 1'b0, 1'b0);
        fp_stop = 1'b1; tk(3'd3, 1'b1, 1'b0);
        tk(3'd3, 1'b1, 1'b0);

        // Reset during an ISTEP wait
        fp_istep = 1'b1; tk(3'd5, 1'b0, 1'b0);
        tk(3'd5, 1'b0, 1'b0);
        reset = 1'b1; tk(3'd0, 1'b1, 1'b0);
        reset = 1'b0; wait_req = 1'b0;
        repeat (15) tk(3'd0, 1'b1, 1'b0);
        tk(3'd1, 1'b1, 1'b0);

        // Drain the scoreboard, bounded
        for (int k = 0; k < 5; k++) begin
            if (q.size() == 0) break;
            @(negedge clk4);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
